// File: rtl/instr_sequencer_pkg.sv
// Shared constants and state encoding for the instruction sequencer.
// Opcodes, word width and FSM states are reused by the control unit and the bench.
package instr_sequencer_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOOP = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_sequencer_loop_counter.sv
// Single-level loop counter: remaining-repeat count plus an armed flag.
// step at count 0 disarms so the next loop instruction starts a fresh loop.
module loop_counter (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       step,
  input  logic [3:0] load_val,
  output logic [3:0] loop_cnt,
  output logic       loop_armed
);

  always_ff @(posedge clock) begin
    if (!rst_n || clr) begin
      loop_cnt   <= '0;
      loop_armed <= 1'b0;
    end else if (load) begin
      loop_cnt   <= load_val;
      loop_armed <= 1'b1;
    end else if (step) begin
      if (loop_cnt != 4'd0) begin
        loop_cnt <= loop_cnt - 4'd1;
      end else begin
        loop_armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/WB control with single-level loops.
// Strobes are decoded from the registered state so each is glitch-free and one-hot.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [15:0] PROG_LEN = 16'd256,
  parameter logic [3:0]  OP_NOP   = instr_sequencer_pkg::OP_NOP,
  parameter logic [3:0]  OP_LOOP  = instr_sequencer_pkg::OP_LOOP,
  parameter logic [3:0]  OP_HALT  = instr_sequencer_pkg::OP_HALT
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] instr,
  input  logic              stall,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] instr_q,
  output logic              en_sel_mem,
  output logic              en_alu,
  output logic              we_mem,
  output logic              busy,
  output logic              halted
);

  localparam logic [WORD_W-1:0] LAST_PC = PROG_LEN - 16'd1;

  state_t            state, state_d;
  logic [WORD_W-1:0] pc_d, instr_q_d;
  logic [3:0]        opcode, rep_n;
  logic [7:0]        target;
  logic [3:0]        loop_cnt;
  logic              loop_armed;
  logic              lc_clr, lc_load, lc_step;
  logic              loop_jump;

  assign opcode = instr_q[15:12];
  assign rep_n  = instr_q[11:8];
  assign target = instr_q[7:0];

  // A jump is taken when a fresh loop arms, or an armed loop still has repeats left.
  assign loop_jump = (opcode == OP_LOOP) &&
                     ((!loop_armed && (rep_n != 4'd0)) || (loop_armed && (loop_cnt != 4'd0)));

  loop_counter u_loop_counter (
    .clock      (clock),
    .rst_n      (rst_n),
    .clr        (lc_clr),
    .load       (lc_load),
    .step       (lc_step),
    .load_val   (rep_n - 4'd1),
    .loop_cnt   (loop_cnt),
    .loop_armed (loop_armed)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      instr_q <= instr_q_d;
    end
  end

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    instr_q_d = instr_q;
    lc_clr    = 1'b0;
    lc_load   = 1'b0;
    lc_step   = 1'b0;
    case (state)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_FETCH;
          lc_clr  = 1'b1;
        end
      end
      S_FETCH: begin
        instr_q_d = instr;
        state_d   = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!stall) state_d = S_WB;
      end
      S_WB: begin
        if (opcode == OP_LOOP) begin
          lc_load = !loop_armed && (rep_n != 4'd0);
          lc_step = loop_armed;
        end
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (loop_jump) begin
          pc_d    = {8'd0, target};
          state_d = S_FETCH;
        end else if (pc == LAST_PC) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc + 16'd1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          lc_clr  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en_sel_mem = (state == S_DECODE);
  assign en_alu     = (state == S_EXEC);
  assign we_mem     = (state == S_WB) && (opcode != OP_NOP) &&
                      (opcode != OP_LOOP) && (opcode != OP_HALT);
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench: an instruction-level interpreter expands each program into an expected
// per-cycle trace, which is compared against the sequencer outputs.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int unsigned LEN = 16;

  typedef struct packed {
    logic        busy;
    logic        halted;
    logic        sel;
    logic        alu;
    logic        we;
    logic [15:0] pc;
    logic [15:0] iq;
    logic        stall;
  } step_t;

  logic        clock = 1'b0;
  logic        rst_n, start, stall;
  logic [15:0] instr, pc, instr_q;
  logic        en_sel_mem, en_alu, we_mem, busy, halted;

  logic [15:0] mem [LEN];
  step_t       trace [$];
  logic [15:0] m_iq, m_pc_end;
  int          fixed_stall = -1;
  int          checks = 0;
  int          errors = 0;
  int          we_count = 0;
  int          alu_count = 0;

  instr_sequencer #(.PROG_LEN(16'd16)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .instr      (instr),
    .stall      (stall),
    .pc         (pc),
    .instr_q    (instr_q),
    .en_sel_mem (en_sel_mem),
    .en_alu     (en_alu),
    .we_mem     (we_mem),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  assign instr = (pc < 16'(LEN)) ? mem[pc[3:0]] : '0;

  always @(negedge clock) begin
    if (we_mem === 1'b1) we_count++;
    if (en_alu === 1'b1) alu_count++;
  end

  task automatic check_eq(input string tag, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] observed();
    return {busy, halted, en_sel_mem, en_alu, we_mem, pc, instr_q};
  endfunction

  function automatic logic [36:0] expect_of(input step_t s);
    return {s.busy, s.halted, s.sel, s.alu, s.we, s.pc, s.iq};
  endfunction

  function automatic step_t mk(input logic sel, input logic alu, input logic we,
                               input int unsigned p, input logic [15:0] iq, input logic st);
    step_t s;
    s.busy = 1'b1; s.halted = 1'b0;
    s.sel = sel; s.alu = alu; s.we = we;
    s.pc = 16'(p); s.iq = iq; s.stall = st;
    return s;
  endfunction

  // Interprets the program one instruction at a time; returns 0 if it does not halt soon.
  function automatic bit build_trace();
    int unsigned p, cnt, k;
    bit          armed, jump;
    logic [15:0] iq, w;
    logic [3:0]  op;
    p = 0; cnt = 0; armed = 1'b0; iq = m_iq;
    trace.delete();
    for (int n = 0; n < 80; n++) begin
      w  = mem[p];
      op = w[15:12];
      k  = (fixed_stall >= 0) ? int'(fixed_stall) : $urandom_range(0, 3);
      trace.push_back(mk(1'b0, 1'b0, 1'b0, p, iq, 1'($urandom)));
      iq = w;
      trace.push_back(mk(1'b1, 1'b0, 1'b0, p, iq, 1'($urandom)));
      for (int unsigned j = 0; j <= k; j++)
        trace.push_back(mk(1'b0, 1'b1, 1'b0, p, iq, j < k));
      trace.push_back(mk(1'b0, 1'b0, (op != OP_NOP) && (op != OP_LOOP) && (op != OP_HALT),
                         p, iq, 1'($urandom)));
      if (op == OP_HALT) begin
        m_iq = iq; m_pc_end = 16'(p);
        return 1'b1;
      end
      jump = 1'b0;
      if (op == OP_LOOP) begin
        if (!armed && w[11:8] != 4'd0) begin
          armed = 1'b1; cnt = int'(w[11:8]) - 1; jump = 1'b1;
        end else if (armed && cnt != 0) begin
          cnt--; jump = 1'b1;
        end else begin
          armed = 1'b0;
        end
      end
      if (jump) begin
        p = int'(w[7:0]);
      end else if (p == LEN - 1) begin
        m_iq = iq; m_pc_end = 16'(p);
        return 1'b1;
      end else begin
        p++;
      end
    end
    return 1'b0;
  endfunction

  task automatic gen_program();
    int unsigned r;
    for (int a = 0; a < int'(LEN); a++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      mem[a] = {OP_HALT, 12'($urandom)};
      else if (r == 1) mem[a] = {OP_NOP, 12'($urandom)};
      else if (r <= 3) mem[a] = {OP_LOOP, 4'($urandom_range(0, 3)), 8'($urandom_range(0, a))};
      else             mem[a] = {4'($urandom_range(1, 13)), 12'($urandom)};
    end
  endtask

  // Entered just after a negedge with the DUT idle or halted.
  task automatic run_prog(input int abort_at);
    start = 1'b1;
    stall = 1'($urandom);
    foreach (trace[i]) begin
      @(negedge clock);
      check_eq($sformatf("step%0d", i), observed(), expect_of(trace[i]));
      if (i == abort_at) begin
        rst_n = 1'b0; start = 1'b1; stall = 1'b1;
        @(negedge clock);
        check_eq("abort_reset", observed(), '0);
        rst_n = 1'b1; start = 1'b0; stall = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clock);
          check_eq("abort_idle", observed(), '0);
        end
        m_iq = '0;
        return;
      end
      stall = trace[i].stall;
      start = 1'($urandom);
    end
    @(negedge clock);
    start = 1'b0;
    check_eq("halted", observed(), {2'b01, 3'b000, m_pc_end, m_iq});
    @(negedge clock);
    check_eq("halt_hold", observed(), {2'b01, 3'b000, m_pc_end, m_iq});
  endtask

  task automatic run_directed(input string tag, input int abort_at);
    if (!build_trace()) begin
      $display("FAIL %s program did not terminate in model", tag);
      $fatal(1);
    end
    we_count = 0; alu_count = 0;
    run_prog(abort_at);
  endtask

  int pick;
  bit ok;

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    for (int a = 0; a < int'(LEN); a++) mem[a] = 16'hF000;
    repeat (2) @(negedge clock);
    check_eq("reset", observed(), '0);
    rst_n = 1'b1;
    @(negedge clock);
    check_eq("idle_hold", observed(), '0);
    m_iq = '0;

    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hF000;
    fixed_stall = 0;
    run_directed("add_sub_halt", -1);
    check_eq("ash_we", 37'(we_count), 37'd2);
    check_eq("ash_alu", 37'(alu_count), 37'd3);

    fixed_stall = 3;
    run_directed("stall3", -1);
    check_eq("stall_we", 37'(we_count), 37'd2);
    check_eq("stall_alu", 37'(alu_count), 37'd12);

    fixed_stall = 0;
    mem[0] = 16'h1001; mem[1] = 16'hE200; mem[2] = 16'hF000;
    run_directed("loop_n2", -1);
    check_eq("loop2_we", 37'(we_count), 37'd3);
    check_eq("loop2_alu", 37'(alu_count), 37'd7);

    mem[1] = 16'hE000;
    run_directed("loop_n0", -1);
    check_eq("loop0_we", 37'(we_count), 37'd1);
    check_eq("loop0_alu", 37'(alu_count), 37'd3);

    fixed_stall = -1;
    for (int a = 0; a < int'(LEN); a++) mem[a] = 16'h3000 + 16'(a);
    run_directed("no_halt", -1);
    check_eq("no_wrap_pc", 37'(pc), 37'd15);
    check_eq("no_halt_we", 37'(we_count), 37'd16);

    mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'hF000;
    fixed_stall = 2;
    run_directed("abort_exec", 2);
    check_eq("abort_we", 37'(we_count), 37'd0);

    fixed_stall = -1;
    for (int t = 0; t < 30; t++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        gen_program();
        ok = build_trace();
      end
      if (!ok) begin
        for (int a = 0; a < int'(LEN); a++) mem[a] = 16'h4000 + 16'(a);
        ok = build_trace();
      end
      pick = -1;
      if (t % 5 == 4) begin
        pick = int'($urandom_range(0, trace.size() - 1));
        while (!trace[pick].alu) pick = (pick + 1) % trace.size();
      end
      run_prog(pick);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PROG_LEN, default 16'd256: number of instruction-memory words; the highest valid pc is PROG_LEN-1.
REQ-002 Parameter OP_NOP, default 4'h0: opcode with no memory write.
REQ-003 Parameter OP_LOOP, default 4'hE: loop opcode. instr[11:8] is N, the number of extra repeats; instr[7:0] is the target address.
REQ-004 Parameter OP_HALT, default 4'hF: stop opcode.
REQ-005 clock  in  1  sole clock; all flops update on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-007 start  in  1  level request to begin or restart the program at pc 0.
REQ-008 instr  in  16  instruction word from instruction memory at address pc; valid one cycle after pc changes.
REQ-009 stall  in  1  datapath hold request; sampled only in EXEC.
REQ-010 pc  out  16  registered instruction-memory address.
REQ-011 instr_q  out  16  instruction latched in FETCH; drives the field and opcode buses to the CU and memories.
REQ-012 en_sel_mem  out  1  selector-register enable.
REQ-013 en_alu  out  1  ALU enable.
REQ-014 we_mem  out  1  data-memory write strobe.
REQ-015 busy  out  1  high in every state except IDLE and HALT.
REQ-016 halted  out  1  high in HALT.

Function
REQ-017 The FSM SHALL have six states, IDLE, FETCH, DECODE, EXEC, WB and HALT, with each one-hot encoded or binary (implementer's choice).
REQ-018 IDLE SHALL go to FETCH on start=1, otherwise stay; pc SHALL hold 0 in IDLE.
REQ-019 FETCH SHALL latch instr into instr_q and go to DECODE unconditionally.
REQ-020 DECODE SHALL assert en_sel_mem for exactly one cycle and go to EXEC.
REQ-021 EXEC SHALL assert en_alu and SHALL stay in EXEC while stall=1; it SHALL go to WB on the first cycle with stall=0.
REQ-022 WB SHALL assert we_mem for exactly one cycle only when instr_q[15:12] is not OP_NOP, OP_LOOP or OP_HALT.
REQ-023 WB SHALL update pc and go to FETCH, except in the two cases given in REQ-028 and REQ-029.
REQ-024 An unstalled instruction SHALL take exactly 4 cycles; each stall cycle SHALL add one cycle.
REQ-025 en_sel_mem, en_alu and we_mem SHALL be mutually exclusive and SHALL be low outside their own states.
REQ-026 Loop state SHALL be a 4-bit loop_cnt register plus a loop_armed flag.
REQ-027 OP_LOOP in WB SHALL act as follows:
 - If loop_armed=0 and N!=0: set loop_armed=1, loop_cnt=N-1, pc={8'd0,target}.
 - If loop_armed=0 and N=0: pc=pc+1 (fall through).
 - If loop_armed=1 and loop_cnt!=0: loop_cnt=loop_cnt-1, pc=target.
 - If loop_armed=1 and loop_cnt=0: loop_armed=0, pc=pc+1.
 - Net effect: the loop body runs N+1 times. Nested loops are not supported; an inner OP_LOOP shares the same counter.
REQ-028 OP_HALT in WB SHALL go to HALT with pc held.
REQ-029 WB with pc=PROG_LEN-1 and no loop jump taken SHALL go to HALT with pc held (no wrap-around).
REQ-030 HALT SHALL go to FETCH on start=1 with pc=0, loop_armed=0 and loop_cnt=0; otherwise it SHALL hold.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 pc arithmetic SHALL be 16-bit unsigned; a loop target SHALL be zero-extended from 8 bits.

Reset
REQ-033 When rst_n=0 on a rising edge of clock: state=IDLE, pc=0, instr_q=0, loop_cnt=0, loop_armed=0, and en_sel_mem, en_alu, we_mem, busy and halted all 0.
REQ-034 Reset SHALL take priority over start and stall, and SHALL abort an instruction mid-execution; the aborted instruction's we_mem SHALL never assert.
REQ-035 After rst_n returns high, the first FETCH SHALL occur one cycle after start is sampled high.

Structure
REQ-036 A shared package SHALL hold the opcode constants OP_NOP, OP_LOOP and OP_HALT, the state encoding, and the 16-bit word width, for reuse by the CU and the testbench.
REQ-037 The loop counter (loop_cnt plus loop_armed, with load, decrement and clear) SHALL be a separate sub-module named loop_counter; the remaining logic SHALL be flat.

Verification
REQ-038 Reset, start pulse, program {ADD, SUB, HALT}, no stall: pc goes 0->1->2, en_sel_mem/en_alu/we_mem pulse on cycles 2/3/4 of each instruction, we_mem pulses twice, halted=1 at cycle 12, pc=2.
REQ-039 stall=1 for 3 cycles during EXEC of instruction 0: en_alu is high for 4 cycles, the WB we_mem pulse arrives 3 cycles late, and there is no duplicate write.
REQ-040 Program {ADD@0, LOOP N=2 target=0 @1, HALT@2}: ADD writes 3 times, the LOOP executes 3 times with no we_mem, then HALT; a LOOP with N=0 falls through after 1 body pass.
REQ-041 PROG_LEN=4, program with no HALT: after the WB of pc=3, halted=1 and pc stays 3 (no wrap to 0); start then restarts at pc=0.
REQ-042 rst_n=0 asserted in EXEC: the next cycle is IDLE, all outputs 0, and no we_mem pulse occurs; start pulses while busy=1 do not change pc.
